// File: rtl/sim_tdm_stim_gen.sv
// Multi-channel TDM stimulus generator that feeds the FIR filter input in
// place of the ADC/RF front end. Emits one valid per slot with sync/last
// framing, the slot index and a selectable data pattern.
module sim_tdm_stim_gen #(
  parameter int          NUM_CHN      = 4,
  parameter int          NUM_CYCLE    = 4,
  parameter int          DATA_W       = 16,
  parameter int          BURST_FRAMES = 8,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  localparam int         CHN_W        = (NUM_CHN > 1) ? $clog2(NUM_CHN) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en_i,
  input  logic              trig_i,
  input  logic [1:0]        mode_i,
  input  logic [1:0]        data_sel_i,
  output logic              sim_valid_o,
  output logic              sim_sync_o,
  output logic              sim_last_o,
  output logic [CHN_W-1:0]  sim_chn_o,
  output logic [DATA_W-1:0] sim_data_o,
  output logic              busy_o
);

  localparam int CYC_W = (NUM_CYCLE > 1) ? $clog2(NUM_CYCLE) : 1;
  localparam int BC_W  = (BURST_FRAMES > 1) ? $clog2(BURST_FRAMES) : 1;

  localparam logic [CYC_W-1:0] CYC_LAST   = CYC_W'(NUM_CYCLE - 1);
  localparam logic [CHN_W-1:0] SLOT_LAST  = CHN_W'(NUM_CHN - 1);
  localparam logic [BC_W-1:0]  BURST_LAST = BC_W'(BURST_FRAMES - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_CONT   = 2'd1;
  localparam logic [1:0] MODE_BURST  = 2'd2;
  localparam logic [1:0] MODE_FREE   = 2'd3;

  localparam logic [1:0] SEL_TAG  = 2'd0;
  localparam logic [1:0] SEL_RAMP = 2'd1;
  localparam logic [1:0] SEL_LFSR = 2'd2;

  logic [0:0]        state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [CHN_W-1:0]  slot_q, slot_d;
  logic [BC_W-1:0]   burst_q, burst_d;
  logic [DATA_W-1:0] frame_q, frame_d;
  logic [DATA_W-1:0] ramp_q;
  logic [15:0]       lfsr_q, lfsr_nxt;
  logic              trig_r, trig_rise;
  logic              cyc_end, frame_end, valid_d;
  logic [DATA_W-1:0] pat;

  // Frame sequencing: start/restart/stop decisions and slot/cycle counters
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    cyc_d     = cyc_q;
    slot_d    = slot_q;
    burst_d   = burst_q;
    frame_d   = frame_q;
    trig_rise = trig_i & ~trig_r;
    cyc_end   = (cyc_q == CYC_LAST);
    frame_end = cyc_end && (slot_q == SLOT_LAST);
    // Gating with en_i stops a valid that would otherwise be issued on the abort edge.
    valid_d   = en_i && (state_q == ST_RUN) && (cyc_q == '0);

    if (!en_i) begin
      state_d = ST_IDLE;
      cyc_d   = '0;
      slot_d  = '0;
      burst_d = '0;
    end else if (state_q == ST_IDLE) begin
      if ((mode_i == MODE_FREE) || trig_rise) begin
        state_d = ST_RUN;
        mode_d  = mode_i;
        cyc_d   = '0;
        slot_d  = '0;
        burst_d = '0;
      end
    end else begin
      if (frame_end) frame_d = frame_q + DATA_W'(1);

      // A retrigger wins over the end-of-frame decision taken on the same edge.
      if ((mode_q != MODE_FREE) && trig_rise) begin
        cyc_d   = '0;
        slot_d  = '0;
        burst_d = '0;
      end else if (frame_end) begin
        cyc_d  = '0;
        slot_d = '0;
        case (mode_q)
          MODE_SINGLE: state_d = ST_IDLE;
          MODE_CONT:   if (!trig_i) state_d = ST_IDLE;
          MODE_BURST: begin
            if (burst_q == BURST_LAST) begin
              state_d = ST_IDLE;
              burst_d = '0;
            end else begin
              burst_d = burst_q + BC_W'(1);
            end
          end
          default:     state_d = ST_RUN;
        endcase
      end else if (cyc_end) begin
        cyc_d  = '0;
        slot_d = slot_q + CHN_W'(1);
      end else begin
        cyc_d = cyc_q + CYC_W'(1);
      end
    end
  end

  // Sample pattern selection and next LFSR state (x^16+x^14+x^13+x^11+1)
  always_comb begin
    lfsr_nxt = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    case (data_sel_i)
      SEL_TAG:  pat = DATA_W'({frame_q, slot_q});
      SEL_RAMP: pat = ramp_q;
      SEL_LFSR: pat = DATA_W'(lfsr_q);
      default:  pat = '0;
    endcase
  end

  // Sequencer state registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_SINGLE;
      cyc_q   <= '0;
      slot_q  <= '0;
      burst_q <= '0;
      frame_q <= '0;
      trig_r  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cyc_q   <= cyc_d;
      slot_q  <= slot_d;
      burst_q <= burst_d;
      frame_q <= frame_d;
      trig_r  <= trig_i;
    end
  end

  // Output register plus ramp/LFSR generators, which advance only when used
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sim_valid_o <= 1'b0;
      sim_sync_o  <= 1'b0;
      sim_last_o  <= 1'b0;
      sim_chn_o   <= '0;
      sim_data_o  <= '0;
      ramp_q      <= '0;
      lfsr_q      <= LFSR_SEED;
    end else begin
      sim_valid_o <= valid_d;
      sim_sync_o  <= valid_d && (slot_q == '0);
      sim_last_o  <= valid_d && (slot_q == SLOT_LAST);
      if (valid_d) begin
        sim_chn_o  <= slot_q;
        sim_data_o <= pat;
        if (data_sel_i == SEL_RAMP) ramp_q <= ramp_q + DATA_W'(1);
        if (data_sel_i == SEL_LFSR) lfsr_q <= lfsr_nxt;
      end
    end
  end

  assign busy_o = (state_q == ST_RUN);

endmodule

// File: tb/tb_sim_tdm_stim_gen.sv
// Directed bench for sim_tdm_stim_gen: a 4x4 instance with a 3-frame burst
// and a degenerate 1x1 instance. Expected samples are queued when a frame is
// triggered and popped whenever a DUT raises valid.
module tb_sim_tdm_stim_gen;

  localparam int NCYC_A = 4;
  localparam int NCYC_B = 1;

  typedef struct packed {
    logic        sync;
    logic        last;
    logic [1:0]  chn;
    logic [15:0] data;
  } exp_t;

  logic        clk;
  logic        rstn;
  logic        en_a, trig_a, en_b, trig_b;
  logic [1:0]  mode_a, sel_a, mode_b, sel_b;
  logic        valid_a, sync_a, last_a, busy_a;
  logic [1:0]  chn_a;
  logic [15:0] data_a;
  logic        valid_b, sync_b, last_b, busy_b;
  logic [0:0]  chn_b;
  logic [15:0] data_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc_n       = 0;
  int   last_va     = -1;
  int   last_vb     = -1;
  int   syncs_a     = 0;
  int   base;
  bit   chk_gap     = 0;
  logic [15:0] lf;

  sim_tdm_stim_gen #(
    .NUM_CHN(4), .NUM_CYCLE(NCYC_A), .DATA_W(16), .BURST_FRAMES(3), .LFSR_SEED(16'hACE1)
  ) dut_a (
    .clk(clk), .rstn(rstn), .en_i(en_a), .trig_i(trig_a), .mode_i(mode_a),
    .data_sel_i(sel_a), .sim_valid_o(valid_a), .sim_sync_o(sync_a),
    .sim_last_o(last_a), .sim_chn_o(chn_a), .sim_data_o(data_a), .busy_o(busy_a)
  );

  sim_tdm_stim_gen #(
    .NUM_CHN(1), .NUM_CYCLE(NCYC_B), .DATA_W(16), .BURST_FRAMES(3), .LFSR_SEED(16'hACE1)
  ) dut_b (
    .clk(clk), .rstn(rstn), .en_i(en_b), .trig_i(trig_b), .mode_i(mode_b),
    .data_sel_i(sel_b), .sim_valid_o(valid_b), .sim_sync_o(sync_b),
    .sim_last_o(last_b), .sim_chn_o(chn_b), .sim_data_o(data_b), .busy_o(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

  function automatic exp_t mk(input logic sy, input logic la, input logic [1:0] ch,
                              input logic [15:0] d);
    exp_t e;
    e.sync = sy;
    e.last = la;
    e.chn  = ch;
    e.data = d;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and score any valid the DUTs present there.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc_n++;
    if (valid_a) begin
      if (chk_gap && last_va >= 0) check("a_period", cyc_n - last_va, NCYC_A);
      last_va = cyc_n;
      if (sync_a) syncs_a++;
      if (q_a.size() == 0) check("a_spurious_valid", {31'd0, valid_a}, 0);
      else begin
        e = q_a.pop_front();
        check("a_chn",  {30'd0, chn_a}, {30'd0, e.chn});
        check("a_data", {16'd0, data_a}, {16'd0, e.data});
        check("a_sync", {31'd0, sync_a}, {31'd0, e.sync});
        check("a_last", {31'd0, last_a}, {31'd0, e.last});
      end
    end
    if (valid_b) begin
      if (chk_gap && last_vb >= 0) check("b_period", cyc_n - last_vb, NCYC_B);
      last_vb = cyc_n;
      if (q_b.size() == 0) check("b_spurious_valid", {31'd0, valid_b}, 0);
      else begin
        e = q_b.pop_front();
        check("b_chn",  {31'd0, chn_b}, {30'd0, e.chn});
        check("b_data", {16'd0, data_b}, {16'd0, e.data});
        check("b_sync", {31'd0, sync_b}, {31'd0, e.sync});
        check("b_last", {31'd0, last_b}, {31'd0, e.last});
      end
    end
  endtask

  initial begin
    rstn = 1'b0; en_a = 1'b0; trig_a = 1'b0; mode_a = 2'd0; sel_a = 2'd0;
    en_b = 1'b0; trig_b = 1'b0; mode_b = 2'd0; sel_b = 2'd0;
    #1;
    check("rst_valid", {31'd0, valid_a}, 0);
    check("rst_sync",  {31'd0, sync_a}, 0);
    check("rst_last",  {31'd0, last_a}, 0);
    check("rst_chn",   {30'd0, chn_a}, 0);
    check("rst_data",  {16'd0, data_a}, 0);
    check("rst_busy",  {31'd0, busy_a}, 0);
    tick(); tick();
    rstn = 1'b1; en_a = 1'b1;
    tick();

    // Single frame, channel tag pattern, frame count 0
    for (int s = 0; s < 4; s++) q_a.push_back(mk(s == 0, s == 3, 2'(s), 16'(s)));
    mode_a = 2'd0; sel_a = 2'd0; trig_a = 1'b1;
    tick(); trig_a = 1'b0;
    check("t1_busy_start", {31'd0, busy_a}, 1);
    check("t1_no_early_valid", {31'd0, valid_a}, 0);
    tick();
    check("t1_first_valid", {31'd0, valid_a}, 1);
    check("t1_first_sync", {31'd0, sync_a}, 1);
    repeat (20) tick();
    check("t1_busy_end", {31'd0, busy_a}, 0);
    check("t1_drained", q_a.size(), 0);

    // Continuous: trig held 40 clocks gives 3 back-to-back frames (frame count 1..3)
    for (int f = 1; f <= 3; f++)
      for (int s = 0; s < 4; s++) q_a.push_back(mk(s == 0, s == 3, 2'(s), 16'((f << 2) | s)));
    mode_a = 2'd1; trig_a = 1'b1; chk_gap = 1'b1; last_va = -1;
    repeat (40) tick();
    trig_a = 1'b0;
    repeat (20) tick();
    chk_gap = 1'b0;
    check("t2_busy_end", {31'd0, busy_a}, 0);
    check("t2_drained", q_a.size(), 0);

    // Burst of 3 frames with ramp data
    for (int i = 0; i < 12; i++) q_a.push_back(mk(i % 4 == 0, i % 4 == 3, 2'(i % 4), 16'(i)));
    mode_a = 2'd2; sel_a = 2'd1; base = syncs_a; trig_a = 1'b1;
    tick(); trig_a = 1'b0;
    repeat (60) tick();
    check("t3_sync_count", syncs_a - base, 3);
    check("t3_busy_end", {31'd0, busy_a}, 0);
    check("t3_drained", q_a.size(), 0);

    // Burst retriggered in frame 2 after slot 1: 6 samples, then 3 full frames
    for (int i = 0; i < 6; i++) q_a.push_back(mk(i % 4 == 0, i % 4 == 3, 2'(i % 4), 16'(12 + i)));
    for (int i = 0; i < 12; i++) q_a.push_back(mk(i % 4 == 0, i % 4 == 3, 2'(i % 4), 16'(18 + i)));
    base = syncs_a; trig_a = 1'b1;
    tick(); trig_a = 1'b0;
    repeat (21) tick();
    trig_a = 1'b1;
    tick(); trig_a = 1'b0;
    repeat (60) tick();
    check("t3_retrig_sync_count", syncs_a - base, 5);
    check("t3_retrig_drained", q_a.size(), 0);

    // Free run with LFSR data, then abort via en_i right where a valid would start
    lf = 16'hACE1;
    for (int i = 0; i < 12; i++) begin
      q_a.push_back(mk(i % 4 == 0, i % 4 == 3, 2'(i % 4), lf));
      lf = lfsr_step(lf);
    end
    mode_a = 2'd3; sel_a = 2'd2;
    repeat (49) tick();
    en_a = 1'b0;
    tick();
    check("t4_no_valid_after_abort", {31'd0, valid_a}, 0);
    check("t4_busy_after_abort", {31'd0, busy_a}, 0);
    mode_a = 2'd0;
    repeat (5) tick();
    check("t4_drained", q_a.size(), 0);
    en_a = 1'b1;

    // 1 channel x 1 clock: valid/sync/last every clock, ramp data
    for (int i = 0; i < 6; i++) q_b.push_back(mk(1'b1, 1'b1, 2'd0, 16'(i)));
    en_b = 1'b1; mode_b = 2'd1; sel_b = 2'd1; chk_gap = 1'b1; last_vb = -1; trig_b = 1'b1;
    repeat (6) tick();
    trig_b = 1'b0;
    repeat (5) tick();
    chk_gap = 1'b0;
    check("t5_busy_end", {31'd0, busy_b}, 0);
    check("t5_drained", q_b.size(), 0);

    // Asynchronous reset mid-frame, then confirm ramp and LFSR reseeded
    q_a.push_back(mk(1'b1, 1'b0, 2'd0, 16'd30));
    q_a.push_back(mk(1'b0, 1'b0, 2'd1, 16'd31));
    mode_a = 2'd0; sel_a = 2'd1; trig_a = 1'b1;
    tick(); trig_a = 1'b0;
    repeat (6) tick();
    check("t6_pre_reset_drained", q_a.size(), 0);
    check("t6_pre_reset_busy", {31'd0, busy_a}, 1);
    #2 rstn = 1'b0;
    #1;
    check("t6_rst_valid", {31'd0, valid_a}, 0);
    check("t6_rst_chn",   {30'd0, chn_a}, 0);
    check("t6_rst_data",  {16'd0, data_a}, 0);
    check("t6_rst_busy",  {31'd0, busy_a}, 0);
    check("t6_rst_b_data", {16'd0, data_b}, 0);
    tick();
    rstn = 1'b1;
    tick();
    for (int s = 0; s < 4; s++) q_a.push_back(mk(s == 0, s == 3, 2'(s), 16'(s)));
    trig_a = 1'b1;
    tick(); trig_a = 1'b0;
    repeat (20) tick();
    lf = 16'hACE1;
    for (int s = 0; s < 4; s++) begin
      q_a.push_back(mk(s == 0, s == 3, 2'(s), lf));
      lf = lfsr_step(lf);
    end
    sel_a = 2'd2; trig_a = 1'b1;
    tick(); trig_a = 1'b0;
    repeat (20) tick();
    check("t6_reseed_drained_a", q_a.size(), 0);
    check("t6_drained_b", q_b.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
